// File: rtl/seg_scan_ctrl.sv
// ---------------------------------------------------------------------------
// seg_scan_ctrl
//
// Time-multiplexed scan controller for a common-cathode multi-digit display
// that shares one external 4-to-7 segment decoder. Each digit owns a slot of
// DIV clock cycles. The first BLANK cycles of every slot keep all digits off
// while the decoder settles on the new nibble; the rest of the slot shows the
// decoded segments on the selected digit.
//
// The displayed value is double-buffered: a load goes into a shadow register
// and is promoted to the active register only at the end of a full frame, so
// a frame never shows a mix of old and new digits.
//
// Optional feature (compile-time macro SEG_SCAN_LZS_EN): leading-zero
// suppression. Digit i > 0 stays dark when nibbles i..DIGITS-1 of the active
// value are all zero. Digit 0 is always shown. Slot timing is unaffected.
//
// Parameters
//   DIGITS  number of multiplexed digits (1..8)
//   DIV     clock cycles per digit slot (>= 2)
//   BLANK   dark cycles at the start of each slot (1 <= BLANK < DIV)
//
// Ports
//   clk         in   system clock, rising edge
//   reset       in   asynchronous reset, active-high
//   value       in   4*DIGITS nibbles, nibble i drives digit i (0 = LSD)
//   load        in   one-cycle strobe capturing value into the shadow register
//   dec_in      out  registered nibble to the external decoder
//   seg_in      in   decoder's 7-bit output (combinational from dec_in)
//   seg_out     out  registered segment bus, active-high
//   digit_en    out  registered one-hot digit enable, active-high
//   frame_done  out  one-cycle pulse on the last cycle of each full scan
// ---------------------------------------------------------------------------
module seg_scan_ctrl #(
    parameter int DIGITS = 4,
    parameter int DIV    = 1000,
    parameter int BLANK  = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [4*DIGITS-1:0]   value,
    input  logic                  load,
    output logic [3:0]            dec_in,
    input  logic [6:0]            seg_in,
    output logic [6:0]            seg_out,
    output logic [DIGITS-1:0]     digit_en,
    output logic                  frame_done
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [CW-1:0] CNT_LAST  = CW'(DIV - 1);
    localparam logic [CW-1:0] CNT_BLANK = CW'(BLANK);
    localparam logic [IW-1:0] IDX_LAST  = IW'(DIGITS - 1);

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_SHOW  = 1'b1
    } state_t;

    // Registers
    state_t                r_state;
    logic [CW-1:0]         r_cnt;
    logic [IW-1:0]         r_idx;
    logic [4*DIGITS-1:0]   r_shadow;
    logic [4*DIGITS-1:0]   r_active;
    logic                  r_pending;
    logic [3:0]            r_dec_in;
    logic [6:0]            r_seg_out;
    logic [DIGITS-1:0]     r_digit_en;
    logic                  r_frame_done;

    // Combinational signals
    state_t                w_state_next;
    logic                  w_slot_end;
    logic                  w_frame_end;
    logic [CW-1:0]         w_cnt_next;
    logic [IW-1:0]         w_idx_next;
    logic [4*DIGITS-1:0]   w_active_next;
    logic [DIGITS-1:0]     w_en_next;
    logic [6:0]            w_seg_next;
    logic                  w_suppress;

    // Select nibble i of a packed value without a variable part-select that
    // could run past the vector when DIGITS=1.
    function automatic logic [3:0] f_nibble(input logic [4*DIGITS-1:0] v,
                                            input logic [IW-1:0]       i);
        f_nibble = 4'h0;
        for (int k = 0; k < DIGITS; k++) begin
            if (IW'(k) == i) f_nibble = v[4*k +: 4];
        end
    endfunction

    // Slot and digit counters
    assign w_slot_end  = (r_cnt == CNT_LAST);
    assign w_frame_end = w_slot_end && (r_idx == IDX_LAST);

    always_comb begin
        w_cnt_next = w_slot_end ? '0 : r_cnt + CW'(1);
        w_idx_next = r_idx;
        if (w_slot_end) begin
            w_idx_next = (r_idx == IDX_LAST) ? '0 : r_idx + IW'(1);
        end
    end

    // Active value as it will be after this edge. A load on the frame-end
    // cycle bypasses the shadow so it is shown in the very next frame.
    always_comb begin
        w_active_next = r_active;
        if (w_frame_end) begin
            if (load) begin
                w_active_next = value;
            end else if (r_pending) begin
                w_active_next = r_shadow;
            end
        end
    end

`ifdef SEG_SCAN_LZS_EN
    // Digit idx is a leading zero when it and every higher nibble are zero.
    always_comb begin
        w_suppress = 1'b0;
        for (int k = 1; k < DIGITS; k++) begin
            if ((IW'(k) == r_idx) && ((r_active >> (4*k)) == '0)) begin
                w_suppress = 1'b1;
            end
        end
    end
`else
    assign w_suppress = 1'b0;
`endif

    // FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_BLANK;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next state and next registered outputs. Entering/staying in SHOW
    // keeps idx and active unchanged (a slot boundary always returns to
    // BLANK), so the current idx/active describe the digit being shown.
    always_comb begin
        w_state_next = r_state;
        w_en_next    = '0;
        w_seg_next   = '0;
        case (r_state)
            ST_BLANK: if (w_cnt_next >= CNT_BLANK) w_state_next = ST_SHOW;
            ST_SHOW:  if (w_slot_end)              w_state_next = ST_BLANK;
            default:  w_state_next = ST_BLANK;
        endcase
        if ((w_state_next == ST_SHOW) && !w_suppress) begin
            w_en_next  = DIGITS'(1) << r_idx;
            w_seg_next = seg_in;
        end
    end

    // Datapath registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt        <= '0;
            r_idx        <= '0;
            r_shadow     <= '0;
            r_active     <= '0;
            r_pending    <= 1'b0;
            r_dec_in     <= 4'h0;
            r_seg_out    <= 7'h00;
            r_digit_en   <= '0;
            r_frame_done <= 1'b0;
        end else begin
            r_cnt  <= w_cnt_next;
            r_idx  <= w_idx_next;
            if (load) begin
                r_shadow <= value;
            end
            // A load on the frame-end cycle is consumed immediately.
            if (load) begin
                r_pending <= ~w_frame_end;
            end else if (w_frame_end) begin
                r_pending <= 1'b0;
            end
            r_active <= w_active_next;
            // New nibble at the start of each slot; the decoder has the
            // blanking interval to settle.
            if (w_slot_end) begin
                r_dec_in <= f_nibble(w_active_next, w_idx_next);
            end
            r_seg_out    <= w_seg_next;
            r_digit_en   <= w_en_next;
            r_frame_done <= (w_cnt_next == CNT_LAST) && (w_idx_next == IDX_LAST);
        end
    end

    assign dec_in     = r_dec_in;
    assign seg_out    = r_seg_out;
    assign digit_en   = r_digit_en;
    assign frame_done = r_frame_done;

endmodule

// File: doc/seg_scan_ctrl.md
Name: seg_scan_ctrl

Overview:
- Time-multiplexed scan controller that shares one external 4-to-7 segment decoder across DIGITS common-cathode digits of the frequency-meter display.
- Sequences digit selection, drives the decoder's 4-bit input, and gates the decoder's 7-bit output onto the shared segment bus with a blanking interval between digits.
- Double-buffers the displayed value so a mid-frame update never tears.

Parameters:
- DIGITS, 4, number of multiplexed digits (1..8).
- DIV, 1000, clock cycles per digit slot (>= 2).
- BLANK, 8, cycles at the start of each slot with all digits off (1 <= BLANK < DIV).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous reset, active-high.
- value  input  4*DIGITS  BCD/hex nibbles; nibble i (bits 4i+3:4i) is shown on digit i; digit 0 is least significant.
- load  input  1  one-cycle strobe; captures value into the shadow register.
- dec_in  output  4  nibble driven to the external decoder's 4-bit input.
- seg_in  input  7  decoder's 7-bit segment output (combinational from dec_in).
- seg_out  output  7  registered segment bus to the display, active-high.
- digit_en  output  DIGITS  registered one-hot digit enable, active-high.
- frame_done  output  1  one-cycle pulse at the end of each full scan.

Behaviour:
- Reset (async): cnt=0, idx=0, state=BLANK, shadow=0, active=0, pending=0, dec_in=0, seg_out=0, digit_en=0, frame_done=0.
- cnt is a slot counter of width clog2(DIV) running 0..DIV-1. At cnt=DIV-1 it wraps to 0 and idx advances. idx wraps from DIGITS-1 to 0.
- States:
  - BLANK when cnt < BLANK. digit_en=0, seg_out=0.
  - SHOW when cnt >= BLANK. digit_en = 1<<idx, seg_out = seg_in sampled the previous cycle.
  - Transitions are purely count-driven; there is no other FSM input.
- dec_in is registered. It updates to nibble idx of the next active value at each slot boundary, so the decoder settles during BLANK. It is stable for the whole slot.
- Latency:
  - dec_in changes on the first cycle of a slot.
  - The first SHOW cycle (cnt=BLANK) presents the decoded segments for that dec_in.
- Load / double-buffer:
  - load=1 writes shadow<=value and sets pending.
  - At the frame-boundary edge (cnt=DIV-1, idx=DIGITS-1), if pending: active<=shadow and pending<=0.
  - If load coincides with the frame-boundary cycle, value is transferred directly to active (bypass) and pending ends at 0.
  - active never changes mid-frame.
- frame_done=1 for exactly the frame-boundary cycle.
- Back-to-back loads within one frame: the last one wins.
- DIGITS=1: idx is constant 0 and every slot is a frame boundary.
- Reset asserted mid-scan: all outputs go to 0 immediately (asynchronously). Scan restarts at digit 0 in BLANK after release. The display value is 0 until the next load plus frame boundary.
- seg_in is don't-care during BLANK.

Optional Feature:
- Macro: SEG_SCAN_LZS_EN (leading-zero suppression).
- Defined:
  - During SHOW, digit i is suppressed (digit_en bit stays 0, seg_out=0) if i>0 and nibbles i..DIGITS-1 of active are all 0.
  - Digit 0 is always shown. Slot timing is unchanged.
- Undefined: all digits are shown, including leading zeros.

Test Plan (DIGITS=4, DIV=10, BLANK=2, external decoder instance):
- Reset, then load value=16'h1234 and run 2 frames. In the second frame:
  - digit 0 slot: dec_in=4, seg_out=7'b1100110 during cnt 2..9.
  - digit 3 slot: dec_in=1, seg_out=7'b0000110.
  - digit_en=0 for cnt 0..1 of every slot.
- Load 16'h0000 then 16'h8888 in the same frame (neither on the boundary cycle) -> the next frame shows only 8s (seg 7'b1111111); 0000 is never displayed.
- Load 16'hABCD exactly on the frame_done cycle -> the following frame shows D,C,B,A on digits 0..3 (7'b1011110, 7'b0111001, 7'b1111100, 7'b1110111); pending=0 afterwards.
- frame_done check -> pulses once every 40 cycles, 1 cycle wide, coincident with cnt=9, idx=3.
- Assert reset during digit 2 SHOW -> digit_en, seg_out and dec_in are 0 within the same cycle. After release, the first SHOW is digit 0 at cnt=2 and displays 0 (7'b0111111).
- With SEG_SCAN_LZS_EN and value=16'h0050:
  - digit_en bits 3 and 2 stay 0 throughout.
  - Digit 1 shows 5 (7'b1101101) and digit 0 shows 0.
  - With value=16'h0000, only digit 0 is lit.
